seven_seg_scan_driver: RTL and testbench

//   Time-multiplexed driver for an NUM_DIGITS-digit common-anode/cathode seven-segment display.
//   - Accepts a packed BCD word plus decimal points, and scans one digit per refresh slot.
//   - Supports tear-free frame update, leading-zero suppression, an invalid-digit dash and anti-ghost guard cycles.
//   - Sits between the numeric datapath (counters/ALU results) and the board display pins.

---
 rtl/seven_seg_pkg.sv | 35 +++
 rtl/seven_seg_lut.sv | 11 +
 rtl/seven_seg_scan_driver.sv | 127 ++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared segment encodings and the BCD-to-segment decode used by the scan driver.
// Segment bit order is {a,b,c,d,e,f,g}; patterns are active-high.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0    = 7'b1111110;
    localparam logic [6:0] SEG_1    = 7'b0110000;
    localparam logic [6:0] SEG_2    = 7'b1101101;
    localparam logic [6:0] SEG_3    = 7'b1111001;
    localparam logic [6:0] SEG_4    = 7'b0110011;
    localparam logic [6:0] SEG_5    = 7'b1011011;
    localparam logic [6:0] SEG_6    = 7'b1011111;
    localparam logic [6:0] SEG_7    = 7'b1110000;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1111011;
    localparam logic [6:0] SEG_DASH = 7'b0000001;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    // Non-BCD nibbles render as a dash so a corrupted value is visible on the board.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
        case (digit)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_DASH;
        endcase
    endfunction

endpackage

// File: rtl/seven_seg_lut.sv
// Combinational nibble-to-segment decoder, shared by all digits through the scan mux.
module seven_seg_lut
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    assign o_seg = bcd_to_seg(i_digit);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment driver: one digit per refresh slot, frame-atomic
// display update, leading-zero blanking, invalid-digit dash and anode guard cycles.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 1000,
    parameter int GUARD          = 2,
    parameter int LZ_SUPPRESS    = 1,
    parameter int SEG_ACTIVE_LOW = 0,
    parameter int AN_ACTIVE_LOW  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    blank,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick,
    output logic                    invalid
);

    localparam int   PRE_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int   IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic SEG_POL = (SEG_ACTIVE_LOW != 0);
    localparam logic AN_POL  = (AN_ACTIVE_LOW != 0);

    logic [PRE_W-1:0]        r_presc;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_pending;
    logic [4*NUM_DIGITS-1:0] r_display;
    logic [NUM_DIGITS-1:0]   r_dp_pending;
    logic [NUM_DIGITS-1:0]   r_dp_display;

    logic                    w_pre_tc;
    logic                    w_idx_last;
    logic                    w_wrap;
    logic [4*NUM_DIGITS-1:0] w_next_display;
    logic [NUM_DIGITS-1:0]   w_next_dp;
    logic                    w_next_invalid;
    logic [NUM_DIGITS-1:0]   w_sup;
    logic [NUM_DIGITS-1:0]   w_onehot;
    logic [3:0]              w_digit;
    logic [6:0]              w_seg;
    logic                    w_an_en;
    logic                    w_dp_bit;

    assign w_pre_tc   = (r_presc == PRE_W'(REFRESH_DIV - 1));
    assign w_idx_last = (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_wrap     = w_pre_tc && w_idx_last;

    // A load landing on the wrap edge bypasses pending so it is shown in the very next slot.
    assign w_next_display = load ? bcd_in : r_pending;
    assign w_next_dp      = load ? dp_in  : r_dp_pending;

    always_comb begin : invalid_scan
        w_next_invalid = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            w_next_invalid = w_next_invalid | (w_next_display[4*i +: 4] > 4'd9);
        end
    end

    // Walk from the top digit down; a digit is blank until a non-zero nibble is seen.
    always_comb begin : lz_mask
        logic nz_seen;
        nz_seen = 1'b0;
        w_sup   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            nz_seen  = nz_seen | (r_display[4*i +: 4] != 4'd0);
            w_sup[i] = (LZ_SUPPRESS != 0) && (i > 0) && !nz_seen;
        end
    end

    assign w_digit  = r_display[4*r_idx +: 4];
    assign w_dp_bit = r_dp_display[r_idx];
    assign w_onehot = NUM_DIGITS'(1) << r_idx;
    assign w_an_en  = (r_presc >= PRE_W'(GUARD)) && !blank && !w_sup[r_idx];

    seven_seg_lut u_lut (
        .i_digit (w_digit),
        .o_seg   (w_seg)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc      <= '0;
            r_idx        <= '0;
            r_pending    <= '0;
            r_display    <= '0;
            r_dp_pending <= '0;
            r_dp_display <= '0;
            seg          <= {7{SEG_POL}};
            dp           <= SEG_POL;
            an           <= {NUM_DIGITS{AN_POL}};
            frame_tick   <= 1'b0;
            invalid      <= 1'b0;
        end else begin
            if (w_pre_tc) begin
                r_presc <= '0;
                r_idx   <= w_idx_last ? '0 : r_idx + IDX_W'(1);
            end else begin
                r_presc <= r_presc + PRE_W'(1);
            end

            if (load) begin
                r_pending    <= bcd_in;
                r_dp_pending <= dp_in;
            end

            if (w_wrap) begin
                r_display    <= w_next_display;
                r_dp_display <= w_next_dp;
                invalid      <= w_next_invalid;
            end

            frame_tick <= w_wrap;
            seg        <= w_seg ^ {7{SEG_POL}};
            dp         <= (w_dp_bit & ~w_sup[r_idx]) ^ SEG_POL;
            an         <= (w_an_en ? w_onehot : '0) ^ {NUM_DIGITS{AN_POL}};
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench: a time-based reference model checked every cycle, plus directed literal checks.
module tb_seven_seg_scan_driver;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int G     = 2;
    localparam int FRAME = N * DIV;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic          blank;
    logic [15:0]   bcd_in;
    logic [3:0]    dp_in;
    logic [6:0]    seg;
    logic          dp;
    logic [3:0]    an;
    logic          frame_tick;
    logic          invalid;

    int checks = 0;
    int errors = 0;

    seven_seg_scan_driver #(
        .NUM_DIGITS     (N),
        .REFRESH_DIV    (DIV),
        .GUARD          (G),
        .LZ_SUPPRESS    (1),
        .SEG_ACTIVE_LOW (0),
        .AN_ACTIVE_LOW  (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .blank      (blank),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_tick (frame_tick),
        .invalid    (invalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: scan position derived from cycles elapsed since reset.
    logic [6:0] seg_tbl [16];
    initial begin
        seg_tbl[0]  = 7'b1111110; seg_tbl[1] = 7'b0110000; seg_tbl[2] = 7'b1101101;
        seg_tbl[3]  = 7'b1111001; seg_tbl[4] = 7'b0110011; seg_tbl[5] = 7'b1011011;
        seg_tbl[6]  = 7'b1011111; seg_tbl[7] = 7'b1110000; seg_tbl[8] = 7'b1111111;
        seg_tbl[9]  = 7'b1111011;
        for (int k = 10; k < 16; k++) seg_tbl[k] = 7'b0000001;
    end

    int          m_t = 0;
    logic        m_valid = 1'b0;
    logic [15:0] m_pend, m_disp;
    logic [3:0]  m_dpp, m_dpd;
    logic [6:0]  e_seg;
    logic        e_dp, e_ft, e_inv;
    logic [3:0]  e_an;

    function automatic logic suppressed(input logic [15:0] d, input int i);
        return (i > 0) && ((d >> (4 * i)) == 16'd0);
    endfunction

    function automatic logic any_invalid(input logic [15:0] d);
        logic r = 1'b0;
        for (int i = 0; i < N; i++) r = r | (((d >> (4 * i)) & 16'hF) > 16'd9);
        return r;
    endfunction

    always @(posedge clk) begin : model
        int p, i;
        logic wrap;
        m_valid <= 1'b1;
        if (rst) begin
            m_t = 0; m_pend = '0; m_disp = '0; m_dpp = '0; m_dpd = '0;
            e_seg = '0; e_dp = 1'b0; e_an = '0; e_ft = 1'b0; e_inv = 1'b0;
        end else begin
            p     = m_t % DIV;
            i     = (m_t / DIV) % N;
            e_an  = (p >= G && !blank && !suppressed(m_disp, i)) ? 4'(1 << i) : 4'd0;
            e_seg = seg_tbl[(m_disp >> (4 * i)) & 16'hF];
            e_dp  = m_dpd[i] && !suppressed(m_disp, i);
            wrap  = (p == DIV - 1) && (i == N - 1);
            e_ft  = wrap;
            if (wrap) begin
                m_disp = load ? bcd_in : m_pend;
                m_dpd  = load ? dp_in  : m_dpp;
                e_inv  = any_invalid(m_disp);
            end
            if (load) begin
                m_pend = bcd_in;
                m_dpp  = dp_in;
            end
            m_t++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_seg", 32'(seg), 32'(e_seg));
            check("model_an", 32'(an), 32'(e_an));
            check("model_dp", 32'(dp), 32'(e_dp));
            check("model_frame_tick", 32'(frame_tick), 32'(e_ft));
            check("model_invalid", 32'(invalid), 32'(e_inv));
        end
    end

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        load = 1'b1; bcd_in = v; dp_in = d;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_ft();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 100);
        check("frame_tick_seen", 32'(frame_tick), 32'd1);
    endtask

    // From a frame_tick, slot k with the guard elapsed is shown 3 + DIV*k cycles later.
    task automatic slot_check(input string name, input int k, input logic [6:0] s, input logic [3:0] a);
        wait_ft();
        repeat (3 + DIV * k) @(negedge clk);
        check({name, "_an"}, 32'(an), 32'(a));
        if (a != 4'd0) check({name, "_seg"}, 32'(seg), 32'(s));
    endtask

    task automatic first_tick_latency(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 100);
        check(name, 32'(n), 32'(FRAME));
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        rst = 1'b1; load = 1'b0; blank = 1'b0; bcd_in = '0; dp_in = '0;
        repeat (3) @(negedge clk);
        check("rst_an", 32'(an), 32'd0);
        check("rst_seg", 32'(seg), 32'd0);
        check("rst_dp", 32'(dp), 32'd0);
        check("rst_ft", 32'(frame_tick), 32'd0);
        rst = 1'b0;
        first_tick_latency("first_tick_latency");

        // Mid-frame load does not tear the current frame.
        repeat (5) @(negedge clk);
        do_load(16'h1234, 4'b0100);
        check("unchanged_seg", 32'(seg), 32'(7'b1111110));
        wait_ft();
        @(negedge clk); check("guard0_an", 32'(an), 32'd0);
        @(negedge clk); check("guard1_an", 32'(an), 32'd0);
        @(negedge clk); check("slot0_1234_an", 32'(an), 32'b0001);
        check("slot0_1234_seg", 32'(seg), 32'(7'b0110011));
        slot_check("s1_1234", 1, 7'b1111001, 4'b0010);
        slot_check("s2_1234", 2, 7'b1101101, 4'b0100);
        slot_check("s3_1234", 3, 7'b0110000, 4'b1000);

        // Leading-zero suppression.
        do_load(16'h0007, 4'b1111);
        slot_check("s0_0007", 0, 7'b1110000, 4'b0001);
        slot_check("s1_0007", 1, 7'b0, 4'b0000);
        slot_check("s3_0007", 3, 7'b0, 4'b0000);
        do_load(16'h0000, 4'b0000);
        slot_check("s0_0000", 0, 7'b1111110, 4'b0001);
        slot_check("s2_0000", 2, 7'b0, 4'b0000);

        // Invalid digit renders a dash and counts as non-zero.
        do_load(16'h00A5, 4'b0000);
        wait_ft();
        check("invalid_a5", 32'(invalid), 32'd1);
        slot_check("s1_00a5", 1, 7'b0000001, 4'b0010);
        slot_check("s0_00a5", 0, 7'b1011011, 4'b0001);
        slot_check("s2_00a5", 2, 7'b0, 4'b0000);

        // Blank darkens anodes from the next cycle while the scan keeps running.
        do_load(16'h8888, 4'b0000);
        wait_ft();
        repeat (4) @(negedge clk);
        blank = 1'b1;
        @(negedge clk);
        check("blank_an", 32'(an), 32'd0);
        wait_ft();
        blank = 1'b0;
        slot_check("s2_unblank", 2, 7'b1111111, 4'b0100);

        // Last load before the wrap wins.
        wait_ft();
        repeat (3) @(negedge clk);
        do_load(16'h1111, 4'b0000);
        repeat (3) @(negedge clk);
        do_load(16'h2222, 4'b0000);
        slot_check("s1_last_wins", 1, 7'b1101101, 4'b0010);

        // Load on the wrap cycle goes straight to the display.
        n = 0;
        while ((m_t % FRAME) != FRAME - 1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        do_load(16'h9999, 4'b0000);
        check("wrap_load_ft", 32'(frame_tick), 32'd1);
        repeat (3) @(negedge clk);
        check("wrap_load_an", 32'(an), 32'b0001);
        check("wrap_load_seg", 32'(seg), 32'(7'b1111011));

        // Reset mid-slot, with a load held during reset that must be ignored.
        repeat (12) @(negedge clk);
        rst = 1'b1; load = 1'b1; bcd_in = 16'h8888;
        @(negedge clk);
        check("midrst_an", 32'(an), 32'd0);
        check("midrst_seg", 32'(seg), 32'd0);
        check("midrst_ft", 32'(frame_tick), 32'd0);
        check("midrst_invalid", 32'(invalid), 32'd0);
        rst = 1'b0; load = 1'b0;
        first_tick_latency("midrst_tick_latency");
        repeat (3) @(negedge clk);
        check("midrst_slot0_seg", 32'(seg), 32'(7'b1111110));
        check("midrst_slot0_an", 32'(an), 32'b0001);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
